// File: rtl/blk_pkg.sv
// rtl/blk_pkg.sv - shared FSM state type and default geometry for the block sequencer
package blk_pkg;

  typedef enum logic [1:0] {
    ST_WAIT_VS = 2'd0,
    ST_ACTIVE  = 2'd1,
    ST_VDELAY  = 2'd2,
    ST_ERR     = 2'd3
  } blk_state_e;

  localparam int DEF_HBLKS = 10;
  localparam int DEF_VBLKS = 10;
  localparam int DEF_BW    = 30;
  localparam int DEF_BH    = 30;
  localparam int DEF_VDLY  = 8;

endpackage

// File: rtl/blk_mod_cnt.sv
// rtl/blk_mod_cnt.sv - modulo-MOD counter with clear, enable and terminal-count flag
module blk_mod_cnt #(
  parameter int MOD = 2,
  parameter int W   = (MOD > 1) ? $clog2(MOD) : 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o,
  output logic         tc_o
);

  assign tc_o = (cnt_o == W'(MOD - 1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_o <= '0;
    end else if (clr_i) begin
      cnt_o <= '0;
    end else if (en_i) begin
      cnt_o <= tc_o ? '0 : cnt_o + W'(1);
    end
  end

endmodule

// File: rtl/blk_sequencer.sv
// rtl/blk_sequencer.sv - frame/line/block boundary sequencer feeding a block accumulator
module blk_sequencer
  import blk_pkg::*;
#(
  parameter int HBLKS = DEF_HBLKS,
  parameter int VBLKS = DEF_VBLKS,
  parameter int BW    = DEF_BW,
  parameter int BH    = DEF_BH,
  parameter int VDLY  = DEF_VDLY
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     de_i,
  input  logic                     vs_i,
  output logic                     h_save_o,
  output logic                     v_save_o,
  output logic [$clog2(HBLKS)-1:0] hblk_o,
  output logic [$clog2(VBLKS)-1:0] vblk_o,
  output logic                     frame_o,
  output logic                     err_o
);

  localparam int PW = (BW > 1) ? $clog2(BW) : 1;
  localparam int HW = $clog2(HBLKS);
  localparam int LW = (BH > 1) ? $clog2(BH) : 1;
  localparam int VW = $clog2(VBLKS);
  localparam int DW = $clog2(VDLY);

  blk_state_e    state;
  logic          vs_q;
  logic          de_q;
  logic          line_full;
  logic [DW-1:0] dcnt;

  logic          vs_rise;
  logic          de_fall;
  logic          active;
  logic          line_ok;
  logic          pix_tc;
  logic          hblk_tc;
  logic          line_tc;
  logic          vblk_tc;
  logic [PW-1:0] pix_cnt;
  logic [LW-1:0] line_cnt;
  logic          unused_cnt;

  assign vs_rise  = vs_i & ~vs_q;
  assign de_fall  = de_q & ~de_i;
  assign active   = (state == ST_ACTIVE);
  // line_full marks that all HBLKS*BW pixels of the line have been seen
  assign h_save_o = active & de_i & pix_tc & ~line_full;
  assign line_ok  = active & de_fall & line_full;

  assign unused_cnt = ^{pix_cnt, line_cnt};

  blk_mod_cnt #(.MOD(BW), .W(PW)) u_pix_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (vs_rise | de_fall),
    .en_i  (active & de_i & ~line_full),
    .cnt_o (pix_cnt),
    .tc_o  (pix_tc)
  );

  blk_mod_cnt #(.MOD(HBLKS), .W(HW)) u_hblk_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (vs_rise | de_fall),
    .en_i  (h_save_o),
    .cnt_o (hblk_o),
    .tc_o  (hblk_tc)
  );

  blk_mod_cnt #(.MOD(BH), .W(LW)) u_line_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (vs_rise),
    .en_i  (line_ok),
    .cnt_o (line_cnt),
    .tc_o  (line_tc)
  );

  blk_mod_cnt #(.MOD(VBLKS), .W(VW)) u_vblk_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (vs_rise),
    .en_i  (v_save_o),
    .cnt_o (vblk_o),
    .tc_o  (vblk_tc)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= ST_WAIT_VS;
      vs_q      <= 1'b1;  // a vs_i already high at release is not a frame start
      de_q      <= 1'b0;
      line_full <= 1'b0;
      dcnt      <= '0;
      v_save_o  <= 1'b0;
      frame_o   <= 1'b0;
      err_o     <= 1'b0;
    end else begin
      vs_q     <= vs_i;
      de_q     <= de_i;
      v_save_o <= 1'b0;
      frame_o  <= 1'b0;

      if (vs_rise || de_fall) begin
        line_full <= 1'b0;
      end else if (h_save_o && hblk_tc) begin
        line_full <= 1'b1;
      end

      case (state)
        ST_WAIT_VS: begin
          if (vs_rise) begin
            state <= ST_ACTIVE;
          end
        end
        ST_ACTIVE: begin
          if (vs_rise) begin
            err_o <= 1'b1;
          end else if ((de_i && line_full) || (de_fall && !line_full)) begin
            err_o <= 1'b1;
            state <= ST_ERR;
          end else if (line_ok && line_tc) begin
            dcnt  <= '0;
            state <= ST_VDELAY;
          end
        end
        ST_VDELAY: begin
          // v_save_o lands VDLY cycles after the de_i fall; stay here through that pulse
          if (vs_rise) begin
            err_o <= 1'b1;
            state <= ST_ACTIVE;
          end else if (de_i) begin
            err_o <= 1'b1;
            state <= ST_ERR;
          end else if (v_save_o) begin
            frame_o <= vblk_tc;
            state   <= vblk_tc ? ST_WAIT_VS : ST_ACTIVE;
          end else begin
            dcnt <= dcnt + DW'(1);
            if (dcnt == DW'(VDLY - 2)) begin
              v_save_o <= 1'b1;
            end
          end
        end
        ST_ERR: begin
          // the vs_i edge that ends ERR also starts the new frame
          if (vs_rise) begin
            state <= ST_ACTIVE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_blk_sequencer.sv
// tb/tb_blk_sequencer.sv - scoreboard bench for blk_sequencer with a line-level reference model
module tb_blk_sequencer;

  localparam int HBLKS = 4;
  localparam int VBLKS = 2;
  localparam int BW    = 3;
  localparam int BH    = 2;
  localparam int VDLY  = 8;
  localparam int LINE  = HBLKS * BW;

  localparam int EV_H     = 0;
  localparam int EV_V     = 1;
  localparam int EV_F     = 2;
  localparam int P_ZERO   = 3;
  localparam int P_HBLK   = 4;
  localparam int P_VBLK   = 5;
  localparam int P_ERR    = 6;
  localparam int P_QEMPTY = 7;

  typedef struct {
    int kind;
    int cyc;
    int val;
  } ev_t;

  logic clk = 1'b0;
  logic rst_i = 1'b1;
  logic de_i = 1'b0;
  logic vs_i = 1'b0;
  logic h_save_o;
  logic v_save_o;
  logic frame_o;
  logic err_o;
  logic [$clog2(HBLKS)-1:0] hblk_o;
  logic [$clog2(VBLKS)-1:0] vblk_o;

  int  cyc = 0;
  int  n_vec = 0;
  int  n_bad = 0;
  ev_t exp_q[$];
  ev_t pr_q[$];

  bit  m_live = 1'b0;
  bit  m_err  = 1'b0;
  int  m_line = 0;

  blk_sequencer #(
    .HBLKS (HBLKS),
    .VBLKS (VBLKS),
    .BW    (BW),
    .BH    (BH),
    .VDLY  (VDLY)
  ) dut (
    .clk_i    (clk),
    .rst_i    (rst_i),
    .de_i     (de_i),
    .vs_i     (vs_i),
    .h_save_o (h_save_o),
    .v_save_o (v_save_o),
    .hblk_o   (hblk_o),
    .vblk_o   (vblk_o),
    .frame_o  (frame_o),
    .err_o    (err_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic string kname(input int k);
    case (k)
      EV_H:     return "h_save";
      EV_V:     return "v_save";
      EV_F:     return "frame";
      P_ZERO:   return "outputs_zero";
      P_HBLK:   return "hblk_wrap";
      P_VBLK:   return "vblk_row";
      P_ERR:    return "err_flag";
      default:  return "pending_events";
    endcase
  endfunction

  task automatic check_pulse(input int kind, input int val);
    ev_t e;
    n_vec++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL %s cyc=%0d: got pulse val=%0d, required no pulse", kname(kind), cyc, val);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.cyc != cyc || e.val != val)
        begin
          n_bad++;
          $display("FAIL %s: got %s at cyc=%0d val=%0d, required %s at cyc=%0d val=%0d",
                   kname(kind), kname(kind), cyc, val, kname(e.kind), e.cyc, e.val);
        end
    end
  endtask

  task automatic check_probe(input ev_t p);
    int act;
    case (p.kind)
      P_ZERO:  act = int'({h_save_o, v_save_o, frame_o, err_o, hblk_o, vblk_o});
      P_HBLK:  act = int'(hblk_o);
      P_VBLK:  act = int'(vblk_o);
      P_ERR:   act = int'(err_o);
      default: act = exp_q.size();
    endcase
    if (p.kind == P_QEMPTY) exp_q.delete();
    n_vec++;
    if (act != p.val) begin
      n_bad++;
      $display("FAIL %s cyc=%0d: got %0d, required %0d", kname(p.kind), cyc, act, p.val);
    end
  endtask

  // monitor: every output pulse must match the head of the expected-event queue
  always @(negedge clk) begin
    ev_t p;
    if (h_save_o) check_pulse(EV_H, int'(hblk_o));
    if (v_save_o) check_pulse(EV_V, int'(vblk_o));
    if (frame_o)  check_pulse(EV_F, 0);
    while (pr_q.size() > 0 && pr_q[0].cyc <= cyc) begin
      p = pr_q.pop_front();
      check_probe(p);
    end
  end

  task automatic push_ev(input int kind, input int c, input int val);
    ev_t e;
    e.kind = kind;
    e.cyc  = c;
    e.val  = val;
    exp_q.push_back(e);
  endtask

  task automatic probe(input int kind, input int val);
    ev_t e;
    e.kind = kind;
    e.cyc  = cyc;
    e.val  = val;
    pr_q.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      de_i = 1'b0;
      vs_i = 1'b0;
    end
  endtask

  task automatic send_vs();
    if (m_live) m_err = 1'b1;
    m_live = 1'b1;
    m_line = 0;
    repeat (2) begin @(posedge clk); #1; vs_i = 1'b1; end
    repeat (2) begin @(posedge clk); #1; vs_i = 1'b0; end
  endtask

  // model: a line of len pixels followed by gap blank cycles
  task automatic send_line(input int len, input int gap);
    int s;
    int c0;
    int row;
    int nh;
    bit live;
    bit full;
    s    = cyc + 1;
    c0   = s + len;
    live = m_live;
    full = (len == LINE);
    row  = m_line / BH;
    if (live) begin
      nh = (len < LINE) ? len / BW : HBLKS;
      for (int k = 0; k < nh; k++) push_ev(EV_H, s + k * BW + BW - 1, k);
      if (!full) begin
        m_err  = 1'b1;
        m_live = 1'b0;
      end else begin
        if (m_line % BH == BH - 1) begin
          if (gap < VDLY) begin
            m_err  = 1'b1;
            m_live = 1'b0;
          end else begin
            push_ev(EV_V, c0 + VDLY, row);
            if (row == VBLKS - 1) begin
              push_ev(EV_F, c0 + VDLY + 1, 0);
              m_live = 1'b0;
            end
          end
        end
        m_line++;
      end
    end
    for (int i = 0; i < len; i++) begin
      @(posedge clk); #1;
      de_i = 1'b1;
      if (i == 0 && live) probe(P_VBLK, row % VBLKS);
    end
    for (int j = 0; j < gap; j++) begin
      @(posedge clk); #1;
      de_i = 1'b0;
      if (j == 0 && live && full) probe(P_HBLK, 0);
    end
  endtask

  task automatic send_frame();
    send_vs();
    idle($urandom_range(0, 3));
    for (int l = 0; l < VBLKS * BH; l++) send_line(LINE, $urandom_range(10, 14));
  endtask

  initial begin
    int s;
    int bad_len[2];
    bad_len[0] = LINE - 1;
    bad_len[1] = LINE + 1;

    repeat (3) begin @(posedge clk); #1; end
    probe(P_ZERO, 0);
    @(posedge clk); #1;
    rst_i = 1'b0;
    probe(P_ZERO, 0);
    idle(3);

    // clean frames; a line after each frame must be ignored until the next vs_i
    repeat ($urandom_range(2, 3)) begin
      idle($urandom_range(0, 5));
      send_frame();
      send_line(LINE, 10);
      probe(P_ERR, 0);
    end
    idle(5);
    probe(P_QEMPTY, 0);

    // vs_i arriving mid-frame
    send_vs();
    send_line(LINE, 10);
    send_vs();
    for (int l = 0; l < VBLKS * BH; l++) send_line(LINE, $urandom_range(10, 14));
    probe(P_ERR, 1);
    idle(5);
    probe(P_QEMPTY, 0);

    // short and long lines, each followed by recovery on the next frame
    foreach (bad_len[b]) begin
      send_vs();
      send_line(bad_len[b], 10);
      send_line(LINE, 10);
      probe(P_ERR, 1);
      send_frame();
      probe(P_ERR, 1);
      idle(5);
      probe(P_QEMPTY, 0);
    end

    // de_i returns 4 cycles into the vertical delay
    send_vs();
    send_line(LINE, 12);
    send_line(LINE, 4);
    send_line(LINE, 10);
    probe(P_ERR, 1);
    idle(5);
    probe(P_QEMPTY, 0);

    // reset mid-line on pixel 5
    send_vs();
    idle(2);
    s = cyc + 1;
    push_ev(EV_H, s + BW - 1, 0);
    for (int i = 0; i < LINE; i++) begin
      @(posedge clk); #1;
      de_i = 1'b1;
      if (i == 5) begin
        rst_i = 1'b1;
        probe(P_ZERO, 0);
      end
      if (i == 7) rst_i = 1'b0;
    end
    m_live = 1'b0;
    m_err  = 1'b0;
    m_line = 0;
    idle(10);
    send_line(LINE, 10);
    probe(P_ERR, 0);
    send_frame();
    probe(P_ERR, 0);

    idle(20);
    probe(P_QEMPTY, 0);
    @(negedge clk); #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
